// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit and the control unit that drives it.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_4   = 2'd0,
        PC_IMM = 2'd1,
        PC_REG = 2'd2,
        PC_RET = 2'd3
    } pc_sel_e;

    localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/pc_unit_ras_if.sv
// Control-unit <-> PC-unit bundle: next-PC request in, PC and RAS status out.
interface pc_unit_ras_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) ();
    import pc_pkg::*;

    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic            pc_write;
    pc_sel_e         pc_sel;
    logic [XLEN-1:0] imm_in;
    logic [XLEN-1:0] rs1_in;
    logic            ras_push;
    logic            ras_flush;

    logic [XLEN-1:0] pc;
    logic [CntW-1:0] ras_count;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_underflow;
    logic            misalign_err;

    modport master (
        output pc_write, pc_sel, imm_in, rs1_in, ras_push, ras_flush,
        input  pc, ras_count, ras_empty, ras_full, ras_underflow, misalign_err
    );

    modport slave (
        input  pc_write, pc_sel, imm_in, rs1_in, ras_push, ras_flush,
        output pc, ras_count, ras_empty, ras_full, ras_underflow, misalign_err
    );

endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: storage, top pointer and saturating occupancy count.
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [XLEN-1:0]              wdata_i,
    output logic [XLEN-1:0]              rdata_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0] top_q, top_d, waddr;
    logic [CntW-1:0] count_q, count_d;
    logic            we;

    // push+pop together is a swap: the top entry is replaced in place
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = top_q + PtrW'(1);
        if (flush_i) begin
            top_d   = '0;
            count_d = '0;
        end else if (push_i && pop_i) begin
            we    = 1'b1;
            waddr = top_q;
        end else if (push_i) begin
            we      = 1'b1;
            top_d   = top_q + PtrW'(1);
            count_d = (count_q == CntW'(RAS_DEPTH)) ? count_q : count_q + CntW'(1);
        end else if (pop_i && count_q != '0) begin
            top_d   = top_q - PtrW'(1);
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n && we) begin
            mem_q[waddr] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[top_q];
    assign count_o = count_q;

endmodule

// File: rtl/pc_unit_ras.sv
// Program counter with JALR support and a circular return-address stack.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit_ras import pc_pkg::*; #(
    parameter int unsigned    XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned    RAS_DEPTH = 4,
    parameter int unsigned    PC_STEP   = PC_STEP_DEFAULT
) (
    input  logic          clk,
    input  logic          arst_n,
    pc_unit_ras_if.slave  bus
);
    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d, pc_plus, reg_sum, target, ras_rdata;
    logic [CntW-1:0] ras_count;
    logic            under_q, under_d;
    logic            ret_ok, misaligned, push, pop;

    assign pc_plus = pc_q + XLEN'(PC_STEP);
    assign reg_sum = bus.rs1_in + bus.imm_in;
    assign ret_ok  = (ras_count != '0) && !bus.ras_flush;

    always_comb begin
        unique case (bus.pc_sel)
            PC_4:    target = pc_plus;
            PC_IMM:  target = pc_q + bus.imm_in;
            PC_REG:  target = {reg_sum[XLEN-1:1], 1'b0};
            default: target = ras_rdata;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q, mis_d;

    assign misaligned = (bus.pc_sel != PC_4) && (target[1:0] != 2'b00);
    // a return with nothing to pop reports underflow, not misalignment
    assign mis_d = bus.pc_write && misaligned && !(bus.pc_sel == PC_RET && !ret_ok);

    always_ff @(posedge clk) begin
        if (!arst_n) mis_q <= 1'b0;
        else         mis_q <= mis_d;
    end

    assign bus.misalign_err = mis_q;
`else
    assign misaligned       = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        under_d = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (bus.pc_write) begin
            if (bus.pc_sel == PC_RET && !ret_ok) begin
                under_d = 1'b1;
                push    = bus.ras_push;
            end else if (!misaligned) begin
                pc_d = target;
                push = bus.ras_push;
                pop  = (bus.pc_sel == PC_RET);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            pc_q    <= RESET_VEC;
            under_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            under_q <= under_d;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .arst_n  (arst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.ras_flush),
        .wdata_i (pc_plus),
        .rdata_o (ras_rdata),
        .count_o (ras_count)
    );

    assign bus.pc            = pc_q;
    assign bus.ras_count     = ras_count;
    assign bus.ras_empty     = (ras_count == '0);
    assign bus.ras_full      = (ras_count == CntW'(RAS_DEPTH));
    assign bus.ras_underflow = under_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Table-driven bench for pc_unit_ras with an expected-result queue.
module tb_pc_unit_ras;
    import pc_pkg::*;

    typedef struct {
        logic        wr;
        pc_sel_e     sel;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        push;
        logic        flush;
        logic [31:0] pc;
        int          cnt;
        logic        under;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
        logic        under;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_unit_ras_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

    pc_unit_ras #(
        .XLEN      (32),
        .RESET_VEC (32'h0),
        .RAS_DEPTH (4),
        .PC_STEP   (4)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    function automatic vec_t mk(logic wr, pc_sel_e sel, logic [31:0] imm, logic [31:0] rs1,
                                logic push, logic flush, logic [31:0] pc, int cnt,
                                logic under, logic mis);
        vec_t v;
        v.wr = wr; v.sel = sel; v.imm = imm; v.rs1 = rs1; v.push = push; v.flush = flush;
        v.pc = pc; v.cnt = cnt; v.under = under; v.mis = mis;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(int idx, exp_t e);
        chk($sformatf("v%0d pc", idx), bus.pc, e.pc);
        chk($sformatf("v%0d count", idx), 32'(bus.ras_count), e.cnt);
        chk($sformatf("v%0d empty", idx), 32'(bus.ras_empty), 32'(e.cnt == 0));
        chk($sformatf("v%0d full", idx), 32'(bus.ras_full), 32'(e.cnt == 4));
        chk($sformatf("v%0d underflow", idx), 32'(bus.ras_underflow), 32'(e.under));
        chk($sformatf("v%0d misalign", idx), 32'(bus.misalign_err), 32'(e.mis));
    endtask

    task automatic drive(logic wr, pc_sel_e sel, logic [31:0] imm, logic [31:0] rs1,
                         logic push, logic flush);
        bus.pc_write  = wr;
        bus.pc_sel    = sel;
        bus.imm_in    = imm;
        bus.rs1_in    = rs1;
        bus.ras_push  = push;
        bus.ras_flush = flush;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;

        // test 1: sequential stepping and hold
        vecs.push_back(mk(1, PC_4,   0, 0, 0, 0, 32'h4, 0, 0, 0));
        vecs.push_back(mk(1, PC_4,   0, 0, 0, 0, 32'h8, 0, 0, 0));
        vecs.push_back(mk(1, PC_4,   0, 0, 0, 0, 32'hC, 0, 0, 0));
        vecs.push_back(mk(0, PC_4,   0, 0, 0, 0, 32'hC, 0, 0, 0));
        // test 2: relative jump and wrap
        vecs.push_back(mk(1, PC_REG, 0, 32'h100, 0, 0, 32'h100, 0, 0, 0));
        vecs.push_back(mk(1, PC_IMM, 32'hFFFF_FFF8, 0, 0, 0, 32'hF8, 0, 0, 0));
        vecs.push_back(mk(1, PC_REG, 0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0, 0));
        vecs.push_back(mk(1, PC_4,   0, 0, 0, 0, 32'h0, 0, 0, 0));
        // test 3: register jump with bit-0 clear, then the alignment case
        vecs.push_back(mk(1, PC_REG, 32'h10, 32'h2001, 0, 0, 32'h2010, 0, 0, 0));
`ifdef PC_ALIGN_CHECK_EN
        vecs.push_back(mk(1, PC_REG, 0, 32'h2002, 0, 0, 32'h2010, 0, 0, 1));
`else
        vecs.push_back(mk(1, PC_REG, 0, 32'h2002, 0, 0, 32'h2002, 0, 0, 0));
`endif
        vecs.push_back(mk(1, PC_REG, 0, 32'h40, 0, 0, 32'h40, 0, 0, 0));
        // test 4: call, return, underflow
        vecs.push_back(mk(1, PC_IMM, 32'h100, 0, 1, 0, 32'h140, 1, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h44, 0, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h44, 0, 1, 0));
        vecs.push_back(mk(1, PC_4,   0, 0, 0, 0, 32'h48, 0, 0, 0));
        // test 5: five pushes into a 4-deep stack, then drain
        vecs.push_back(mk(1, PC_REG, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0));
        vecs.push_back(mk(1, PC_REG, 0, 32'h10, 1, 0, 32'h10, 1, 0, 0));
        vecs.push_back(mk(1, PC_REG, 0, 32'h20, 1, 0, 32'h20, 2, 0, 0));
        vecs.push_back(mk(1, PC_REG, 0, 32'h30, 1, 0, 32'h30, 3, 0, 0));
        vecs.push_back(mk(1, PC_REG, 0, 32'h40, 1, 0, 32'h40, 4, 0, 0));
        vecs.push_back(mk(1, PC_REG, 0, 32'h50, 1, 0, 32'h50, 4, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h44, 3, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h34, 2, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h24, 1, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h14, 0, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h14, 0, 1, 0));
        // test 6: coroutine swap, flush variants, swap on empty stack
        vecs.push_back(mk(1, PC_REG, 0, 32'h200, 1, 0, 32'h200, 1, 0, 0));
        vecs.push_back(mk(1, PC_REG, 0, 32'h300, 1, 0, 32'h300, 2, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 1, 0, 32'h204, 2, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h304, 1, 0, 0));
        vecs.push_back(mk(0, PC_RET, 0, 0, 0, 1, 32'h304, 0, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h304, 0, 1, 0));
        vecs.push_back(mk(1, PC_IMM, 32'h10, 0, 1, 1, 32'h314, 0, 0, 0));
        vecs.push_back(mk(1, PC_4,   0, 0, 1, 0, 32'h318, 1, 0, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 1, 32'h318, 0, 1, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 1, 0, 32'h318, 1, 1, 0));
        vecs.push_back(mk(1, PC_RET, 0, 0, 0, 0, 32'h31C, 0, 0, 0));
        vecs.push_back(mk(1, PC_4,   0, 0, 1, 0, 32'h320, 1, 0, 0));

        arst_n = 1'b0;
        drive(1'b0, PC_4, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        e = '{pc: 32'h0, cnt: 0, under: 1'b0, mis: 1'b0};
        check_outputs(-1, e);
        @(negedge clk);
        arst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].wr, vecs[i].sel, vecs[i].imm, vecs[i].rs1, vecs[i].push,
                  vecs[i].flush);
            sb.push_back('{pc: vecs[i].pc, cnt: vecs[i].cnt, under: vecs[i].under,
                           mis: vecs[i].mis});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_outputs(i, e);
        end

        // reset in the middle of a call must win over the pending update
        @(negedge clk);
        arst_n = 1'b0;
        drive(1'b1, PC_IMM, 32'h80, 32'h0, 1'b1, 1'b0);
        sb.push_back('{pc: 32'h0, cnt: 0, under: 1'b0, mis: 1'b0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(100, e);

        @(negedge clk);
        arst_n = 1'b1;
        drive(1'b1, PC_RET, 32'h0, 32'h0, 1'b0, 1'b0);
        sb.push_back('{pc: 32'h0, cnt: 0, under: 1'b1, mis: 1'b0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(101, e);

        @(negedge clk);
        drive(1'b1, PC_4, 32'h0, 32'h0, 1'b0, 1'b0);
        sb.push_back('{pc: 32'h4, cnt: 0, under: 1'b0, mis: 1'b0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(102, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
